// File: rtl/m31_multiplier_stream.sv
// Streaming multi-lane Mersenne-31 multiplier with optional fused add.
// Lanes share one valid/ready handshake; the whole pipeline stalls globally.
module m31_multiplier_stream #(
   parameter int LANES           = 1,
   parameter int PIPELINE_STAGES = 7,
   parameter int TAG_WIDTH       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_mode,
   input  logic [LANES*31-1:0]    in_a,
   input  logic [LANES*31-1:0]    in_b,
   input  logic [LANES*31-1:0]    in_c,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*31-1:0]    out_data,
   output logic [TAG_WIDTH-1:0]   out_tag,
   output logic                   busy
);

   localparam int PS  = PIPELINE_STAGES;
   localparam int LW  = LANES * 31;
   localparam int PW  = LANES * 62;
   // Rank 0 is the operand register, ranks 1..PS the product pipe, rank RED the reduction.
   localparam int RED = PS + 1;
   localparam logic [31:0] P_MOD = 32'h7FFF_FFFF;

   function automatic logic [30:0] reduce62(input logic [61:0] x);
      logic [31:0] s;
      logic [31:0] r;
      s = {1'b0, x[30:0]} + {1'b0, x[61:31]};
      r = {1'b0, s[30:0]} + {31'b0, s[31]};
      if (r >= P_MOD) r = r - P_MOD;
      return r[30:0];
   endfunction

   function automatic logic [30:0] add_mod(input logic [30:0] r, input logic [30:0] c);
      logic [31:0] cc;
      logic [31:0] t;
      cc = (c == 31'h7FFF_FFFF) ? 32'd0 : {1'b0, c};
      t  = {1'b0, r} + cc;
      if (t >= P_MOD) t = t - P_MOD;
      return t[30:0];
   endfunction

   logic [RED:0]          r_vld;
   logic [RED:0]          r_mode;
   logic [TAG_WIDTH-1:0]  r_tag [0:RED];
   logic [LW-1:0]         r_c   [0:RED];
   logic [LW-1:0]         r_a;
   logic [LW-1:0]         r_b;
   logic [PW-1:0]         r_prod [1:PS];
   logic [LW-1:0]         r_red;
   logic                  r_out_valid;
   logic [LW-1:0]         r_out_data;
   logic [TAG_WIDTH-1:0]  r_out_tag;

   logic                  w_advance;
   logic [PW-1:0]         w_prod;
   logic [LW-1:0]         w_red;
   logic [LW-1:0]         w_res;

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // ready depends only on the output register state and out_ready, never on in_valid.
   assign w_advance = ~r_out_valid | out_ready;
   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;
   assign busy      = (|r_vld) | r_out_valid;

   always_comb begin
      w_prod = '0;
      w_red  = '0;
      w_res  = '0;
      for (int l = 0; l < LANES; l++) begin
         w_prod[l*62 +: 62] = {31'b0, r_a[l*31 +: 31]} * {31'b0, r_b[l*31 +: 31]};
         w_red[l*31 +: 31]  = reduce62(r_prod[PS][l*62 +: 62]);
         w_res[l*31 +: 31]  = r_mode[RED] ? add_mod(r_red[l*31 +: 31], r_c[RED][l*31 +: 31])
                                          : r_red[l*31 +: 31];
      end
   end

   // Datapath registers carry no reset; only valid bits decide what is meaningful.
   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_a       <= in_a;
         r_b       <= in_b;
         r_c[0]    <= in_c;
         r_tag[0]  <= in_tag;
         r_mode    <= {r_mode[RED-1:0], in_mode};
         r_prod[1] <= w_prod;
         for (int k = 2; k <= PS; k++) begin
            r_prod[k] <= r_prod[k-1];
         end
         r_red <= w_red;
         for (int k = 1; k <= RED; k++) begin
            r_c[k]   <= r_c[k-1];
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
      end else if (w_advance) begin
         r_vld       <= {r_vld[RED-1:0], in_valid & w_advance};
         r_out_valid <= r_vld[RED];
         if (r_vld[RED]) begin
            r_out_data <= w_res;
            r_out_tag  <= r_tag[RED];
         end
      end
   end

endmodule

// File: tb/tb_m31_multiplier_stream.sv
// Scoreboard bench for m31_multiplier_stream: directed vectors, streaming,
// random backpressure and mid-stream reset, checked against a modular model.
module tb_m31_multiplier_stream;

   localparam int LANES = 4;
   localparam int PS    = 7;
   localparam int TW    = 8;
   localparam int LW    = LANES * 31;
   localparam int EW    = TW + LW;
   localparam logic [30:0] P31 = 31'h7FFF_FFFF;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic           in_mode;
   logic [LW-1:0]  in_a;
   logic [LW-1:0]  in_b;
   logic [LW-1:0]  in_c;
   logic [TW-1:0]  in_tag;
   logic           out_valid;
   logic           out_ready;
   logic [LW-1:0]  out_data;
   logic [TW-1:0]  out_tag;
   logic           busy;

   logic [EW-1:0]  exp_q[$];
   int             n_cmp = 0;
   int             n_bad = 0;
   int             cyc   = 0;
   logic           in_xfer = 1'b0;
   logic           tp_on = 1'b0;
   int             tp_n = 0;
   int             tp_first = 0;
   int             tp_last = 0;
   logic           prev_hold = 1'b0;
   logic [LW-1:0]  prev_data;
   logic [TW-1:0]  prev_tag;
   logic [TW-1:0]  tag_ctr = '0;

   m31_multiplier_stream #(
      .LANES(LANES), .PIPELINE_STAGES(PS), .TAG_WIDTH(TW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .busy(busy)
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [30:0] ref_m31(input logic mode, input logic [30:0] a,
                                           input logic [30:0] b, input logic [30:0] c);
      longint unsigned pm, av, bv, cv, x;
      pm = 64'h7FFF_FFFF;
      av = {33'b0, a};
      bv = {33'b0, b};
      cv = {33'b0, c};
      x  = ((av % pm) * (bv % pm)) % pm;
      if (mode) x = (x + (cv % pm)) % pm;
      return x[30:0];
   endfunction

   function automatic logic [EW-1:0] ref_txn();
      logic [LW-1:0] d;
      d = '0;
      for (int l = 0; l < LANES; l++)
         d[l*31 +: 31] = ref_m31(in_mode, in_a[l*31 +: 31], in_b[l*31 +: 31], in_c[l*31 +: 31]);
      return {in_tag, d};
   endfunction

   function automatic logic [30:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 31'd0;
         1:       return P31 - 31'd1;
         2:       return P31;
         3:       return 31'd1;
         default: return 31'($urandom());
      endcase
   endfunction

   // Scoreboard monitor, sampled on the falling edge where inputs are stable
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         check("in_ready", in_ready, {~out_valid | out_ready});
         if (prev_hold) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
            check("stall_tag", out_tag, prev_tag);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", {out_tag, out_data}, '0);
            end else begin
               check("result", {out_tag, out_data}, exp_q.pop_front());
            end
            if (tp_on) begin
               if (tp_n == 0) tp_first = cyc;
               tp_last = cyc;
               tp_n++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_txn());
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_tag  = out_tag;
      end
      in_xfer = !reset && in_valid && in_ready;
   end

   // Driver tasks
   task automatic set_txn(input logic mode, input logic [TW-1:0] tag);
      in_mode = mode;
      in_tag  = tag;
      for (int l = 0; l < LANES; l++) begin
         in_a[l*31 +: 31] = rand_op();
         in_b[l*31 +: 31] = rand_op();
         in_c[l*31 +: 31] = rand_op();
      end
      in_valid = 1'b1;
   endtask

   task automatic drive_one(input logic mode, input logic [30:0] a, input logic [30:0] b,
                            input logic [30:0] c, input logic [TW-1:0] tag);
      int lat;
      @(posedge clk); #1;
      set_txn(mode, tag);
      in_a[30:0] = a;
      in_b[30:0] = b;
      in_c[30:0] = c;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, PS + 2);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_tag", out_tag, '0);
      check("rst_in_ready", in_ready, 1'b1);

      // Directed boundary vectors in lane 0
      out_ready = 1'b1;
      drive_one(1'b0, 31'd2, 31'd3, 31'd0, 8'h01);
      drive_one(1'b0, P31 - 31'd1, P31 - 31'd1, 31'd9, 8'h02);
      drive_one(1'b0, P31, 31'd5, 31'd9, 8'h03);
      drive_one(1'b1, P31 - 31'd1, 31'd2, 31'd3, 8'h04);
      drive_one(1'b1, 31'd0, 31'd0, P31, 8'h05);
      drive_one(1'b1, 31'd1, P31 - 31'd1, P31 - 31'd1, 8'h06);
      wait_drain();

      // Back-to-back streaming at full throughput
      tp_on = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
         set_txn(1'($urandom_range(0, 1)), TW'(i));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();
      tp_on = 1'b0;
      check("tp_count", tp_n, 1000);
      check("tp_span", tp_last - tp_first, 999);

      // Random valid with 30% out_ready
      for (int i = 0; i < 600; i++) begin
         if (!(in_valid && !in_xfer)) begin
            if ($urandom_range(0, 1) == 1) begin
               set_txn(1'($urandom_range(0, 1)), tag_ctr);
               tag_ctr++;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 99) < 30);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Reset with five transactions in flight
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         set_txn(1'($urandom_range(0, 1)), 8'hF0 + TW'(i));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_out_data", out_data, '0);
      for (int i = 0; i < 5; i++)
         drive_one(1'($urandom_range(0, 1)), rand_op(), rand_op(), rand_op(), 8'h20 + TW'(i));
      repeat (30) @(posedge clk);
      #1;
      check("final_queue", exp_q.size(), 0);
      check("final_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
